fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the unified memory/MMU block. It owns the program counter and drives the instruction-side virtual address into the IMEM MMU port. It consumes the returned instruction, stall and fault signals, and presents a registered IF/ID packet to decode under a valid/ready handshake. It applies trap and branch redirects with fixed priority and holds fetch after an instruction fault until a redirect arrives.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- trap_valid  in  1  redirect PC to trap_pc (trap entry, mret, sret).
- trap_pc  in  32  trap/return target.
- br_valid  in  1  redirect PC to br_pc (taken branch or jump resolved downstream).
- br_pc  in  32  branch target.
- id_ready  in  1  decode accepts the IF/ID packet this cycle.
- VPC_IMEM  out  32  current fetch virtual address (the PC register).
- access_is_inst_IMEM  out  1  high whenever state is RUN.
- inst  in  32  instruction returned combinationally for VPC_IMEM.
- stall_IMEM  in  1  MMU walk in progress; inst not valid.
- instr_fault_mmu_IMEM  in  1  page fault on fetch.
- faulting_va_IMEM  in  32  VA reported with the fault.
- if_valid  out  1  IF/ID packet valid.
- if_pc  out  32  PC of the packet.
- if_inst  out  32  instruction; `INST_NOP when the packet carries a fault.
- if_fault  out  2  00 none, 01 misaligned, 10 page fault.
- if_fault_va  out  32  faulting address (PC for misaligned, faulting_va_IMEM for page fault).

## Operation
- States: RUN, HOLD.
- RUN:
  - The fetch is "good" when stall_IMEM=0 and PC[1:0]=00.
  - On a good fetch with no fault and the output slot free (if_valid=0 or id_ready=1): load the packet {PC, inst, fault 00}, set if_valid=1, and set PC ← PC+4. Wraps modulo 2^32.
- Misaligned PC (PC[1:0]≠00) with a free slot: emit packet {PC, `INST_NOP, 01, va=PC} and go to HOLD. The memory result is ignored.
- instr_fault_mmu_IMEM=1 with stall_IMEM=0 and a free slot: emit packet {PC, `INST_NOP, 10, faulting_va_IMEM} and go to HOLD.
- stall_IMEM=1: PC and state are held. The output packet is consumed normally if id_ready=1 (if_valid then drops to 0).
- Slot busy (if_valid=1, id_ready=0): PC, packet and state are all held.
- HOLD:
  - No new packets are issued and PC is frozen.
  - The fault packet drains normally through the handshake.
  - Only a redirect leaves HOLD.
- Redirect priority is trap_valid > br_valid. A redirect takes effect regardless of stall_IMEM, id_ready or state:
  - PC ← target.
  - if_valid ← 0, which squashes the packet in flight.
  - state ← RUN.
  - Any in-progress MMU walk for the old PC is abandoned; the MMU observes the new VPC.
- Simultaneous trap_valid and br_valid: the trap wins and br_pc is discarded.

## Timing
- Reset values:
  - PC=RESET_PC, state RUN, if_valid=0, if_pc=0, if_inst=`INST_NOP, if_fault=00, if_fault_va=0.
  - VPC_IMEM=RESET_PC, access_is_inst_IMEM=1.
- Reset asserted mid-operation forces these values immediately (asynchronous). The first fetch occurs at the first rising edge after deassertion.
- Latency: the packet for PC is registered on the same edge at which a good fetch completes. With no stalls, throughput is 1 packet/cycle.
- Redirect asserted in cycle N:
  - VPC_IMEM shows the target after edge N.
  - The first target packet is valid after edge N+1 at the earliest.
- MMU walk: the PC is held for the full stall duration. The packet loads on the first edge with stall_IMEM=0.
- VPC_IMEM is the PC register directly, not a combinational next-PC.

## Configuration
- FETCH_STATS_EN:
  - Defined: adds output perf_fetched (32b, counts accepted packets, i.e. if_valid&&id_ready), perf_stall_mmu (32b, cycles with stall_IMEM=1 in RUN) and perf_redirect (32b, redirect events). All three reset to 0 and wrap at 2^32.
  - Undefined: these ports and the counters are absent; all other behaviour is identical.

## Structure
- `INST_NOP comes from csr_defs.v.
- Add to csr_defs.v: `FETCH_FAULT_NONE/`FETCH_FAULT_MISALIGN/`FETCH_FAULT_PAGE (2-bit) and the state encodings FETCH_RUN/FETCH_HOLD.
- Sub-module: fetch_perf_counters, instantiated only under FETCH_STATS_EN.

## Test plan
- Reset with RESET_PC=0x100, id_ready=1, memory filled with distinct words -> packets at PCs 0x100, 0x104, 0x108 on consecutive cycles, insts matching memory.
- stall_IMEM held high for 4 cycles at PC 0x200 -> VPC_IMEM stays 0x200, no new packet. The packet for 0x200 appears on the first edge after stall_IMEM falls.
- id_ready=0 for 3 cycles with a packet at 0x300 -> if_pc stays 0x300 and VPC_IMEM stays 0x304. Release -> 0x304 issues next cycle.
- trap_valid and br_valid both high (trap_pc=0x80, br_pc=0x400) while a packet is valid -> if_valid=0 next cycle, VPC_IMEM=0x80, first new packet from 0x80.
- instr_fault_mmu_IMEM at PC 0x1000 with faulting_va_IMEM=0x1000 -> packet if_fault=10, if_inst=NOP, if_fault_va=0x1000. Unit then enters HOLD with no further packets until br_valid (br_pc=0x2000), after which fetch resumes at 0x2000.
- br_pc=0x502 -> one packet with if_fault=01, if_fault_va=0x502. Unit enters HOLD until the next redirect.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch stage.
//   - Carries the csr_defs.v macros the fetch stage relies on (INST_NOP,
//     FETCH_FAULT_*, FETCH_RUN/FETCH_HOLD), guarded so an existing
//     definition from csr_defs.v takes precedence.
//   - Exposes them as typed localparams and a state enum, so the rest of
//     the fetch RTL does not depend on macro visibility.
// Optional feature macro used by this slice: FETCH_STATS_EN (see fetch_unit.sv).

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef FETCH_FAULT_NONE
`define FETCH_FAULT_NONE 2'b00
`endif
`ifndef FETCH_FAULT_MISALIGN
`define FETCH_FAULT_MISALIGN 2'b01
`endif
`ifndef FETCH_FAULT_PAGE
`define FETCH_FAULT_PAGE 2'b10
`endif
`ifndef FETCH_RUN
`define FETCH_RUN 1'b0
`endif
`ifndef FETCH_HOLD
`define FETCH_HOLD 1'b1
`endif

package fetch_unit_pkg;

  localparam logic [31:0] INST_NOP_WORD  = `INST_NOP;
  localparam logic [1:0]  FAULT_NONE     = `FETCH_FAULT_NONE;
  localparam logic [1:0]  FAULT_MISALIGN = `FETCH_FAULT_MISALIGN;
  localparam logic [1:0]  FAULT_PAGE     = `FETCH_FAULT_PAGE;

  typedef enum logic {
    ST_RUN  = `FETCH_RUN,
    ST_HOLD = `FETCH_HOLD
  } fetch_state_e;

  // Only word-aligned PCs may be fetched.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: free-running 32-bit event counters for the fetch stage.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fetched_inc       a packet was accepted by decode this cycle
//   stall_inc         the MMU stalled a RUN-state fetch this cycle
//   redirect_inc      a trap or branch redirect occurred this cycle
//   perf_fetched      accepted-packet count (wraps at 2^32)
//   perf_stall_mmu    MMU stall cycle count (wraps at 2^32)
//   perf_redirect     redirect event count (wraps at 2^32)
// Instantiated by fetch_unit only when FETCH_STATS_EN is defined.

module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetched_inc,
  input  logic        stall_inc,
  input  logic        redirect_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_mmu,
  output logic [31:0] perf_redirect
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= 32'd0;
      perf_stall_mmu <= 32'd0;
      perf_redirect  <= 32'd0;
    end else begin
      if (fetched_inc)  perf_fetched   <= perf_fetched + 32'd1;
      if (stall_inc)    perf_stall_mmu <= perf_stall_mmu + 32'd1;
      if (redirect_inc) perf_redirect  <= perf_redirect + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of the unified memory/MMU.
// Owns the PC, drives it as the IMEM virtual address, and registers an
// IF/ID packet towards decode under a valid/ready handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   trap_valid/trap_pc       highest-priority redirect (trap entry/return)
//   br_valid/br_pc           branch/jump redirect
//   id_ready                 decode accepts the packet this cycle
//   VPC_IMEM                 fetch VA (the PC register itself)
//   access_is_inst_IMEM      high while in RUN
//   inst                     instruction for VPC_IMEM (combinational)
//   stall_IMEM               MMU walk in progress, inst not valid
//   instr_fault_mmu_IMEM     page fault on this fetch
//   faulting_va_IMEM         VA reported with the page fault
//   if_valid/if_pc/if_inst/if_fault/if_fault_va   IF/ID packet
// Optional: FETCH_STATS_EN adds perf_fetched, perf_stall_mmu, perf_redirect.

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        id_ready,
  output logic [31:0] VPC_IMEM,
  output logic        access_is_inst_IMEM,
  input  logic [31:0] inst,
  input  logic        stall_IMEM,
  input  logic        instr_fault_mmu_IMEM,
  input  logic [31:0] faulting_va_IMEM,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [1:0]  if_fault,
  output logic [31:0] if_fault_va
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_mmu,
  output logic [31:0] perf_redirect
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         slot_free;
  logic         redirect;
  logic [31:0]  redirect_pc;

  assign slot_free   = !if_valid || id_ready;
  assign redirect    = trap_valid || br_valid;
  // Trap outranks branch; br_pc is dropped when both fire.
  assign redirect_pc = trap_valid ? trap_pc : br_pc;

  assign VPC_IMEM            = pc;
  assign access_is_inst_IMEM = (state == ST_RUN);

  // PC / IF-ID packet register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_inst     <= INST_NOP_WORD;
      if_fault    <= FAULT_NONE;
      if_fault_va <= 32'd0;
    end else if (redirect) begin
      // Squashes any packet in flight and abandons an outstanding walk.
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      state    <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (slot_free) begin
            if (pc_misaligned(pc[1:0])) begin
              // Memory result is meaningless for a misaligned PC.
              if_valid    <= 1'b1;
              if_pc       <= pc;
              if_inst     <= INST_NOP_WORD;
              if_fault    <= FAULT_MISALIGN;
              if_fault_va <= pc;
              state       <= ST_HOLD;
            end else if (!stall_IMEM && instr_fault_mmu_IMEM) begin
              if_valid    <= 1'b1;
              if_pc       <= pc;
              if_inst     <= INST_NOP_WORD;
              if_fault    <= FAULT_PAGE;
              if_fault_va <= faulting_va_IMEM;
              state       <= ST_HOLD;
            end else if (!stall_IMEM) begin
              if_valid    <= 1'b1;
              if_pc       <= pc;
              if_inst     <= inst;
              if_fault    <= FAULT_NONE;
              if_fault_va <= 32'd0;
              pc          <= pc + 32'd4;
            end else begin
              // Stalled: the current packet (if any) drains.
              if_valid <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (id_ready) if_valid <= 1'b0;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  fetch_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetched_inc    (if_valid && id_ready),
    .stall_inc      (stall_IMEM && (state == ST_RUN)),
    .redirect_inc   (redirect),
    .perf_fetched   (perf_fetched),
    .perf_stall_mmu (perf_stall_mmu),
    .perf_redirect  (perf_redirect)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (RESET_PC = 0x100).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        id_ready;
  logic [31:0] VPC_IMEM;
  logic        access_is_inst_IMEM;
  logic [31:0] inst;
  logic        stall_IMEM;
  logic        instr_fault_mmu_IMEM;
  logic [31:0] faulting_va_IMEM;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  if_fault;
  logic [31:0] if_fault_va;
`ifdef FETCH_STATS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_mmu;
  logic [31:0] perf_redirect;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  assign inst = mem_word(VPC_IMEM);

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .trap_valid           (trap_valid),
    .trap_pc              (trap_pc),
    .br_valid             (br_valid),
    .br_pc                (br_pc),
    .id_ready             (id_ready),
    .VPC_IMEM             (VPC_IMEM),
    .access_is_inst_IMEM  (access_is_inst_IMEM),
    .inst                 (inst),
    .stall_IMEM           (stall_IMEM),
    .instr_fault_mmu_IMEM (instr_fault_mmu_IMEM),
    .faulting_va_IMEM     (faulting_va_IMEM),
    .if_valid             (if_valid),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .if_fault             (if_fault),
    .if_fault_va          (if_fault_va)
`ifdef FETCH_STATS_EN
    ,
    .perf_fetched         (perf_fetched),
    .perf_stall_mmu       (perf_stall_mmu),
    .perf_redirect        (perf_redirect)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] target);
    br_valid = 1'b1;
    br_pc    = target;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trap_valid = 1'b0; trap_pc = 32'd0;
    br_valid = 1'b0;   br_pc = 32'd0;
    id_ready = 1'b1;
    stall_IMEM = 1'b0; instr_fault_mmu_IMEM = 1'b0; faulting_va_IMEM = 32'd0;
    tick(); tick();
    n_total++;
    if ({if_valid, if_pc, if_inst, if_fault, if_fault_va} !== {1'b0, 32'd0, NOP, 2'b00, 32'd0})
      $display("FAIL reset_packet: got v=%b pc=%h inst=%h f=%b va=%h want v=0 pc=0 inst=%h f=00 va=0",
               if_valid, if_pc, if_inst, if_fault, if_fault_va, NOP);
    else n_pass++;
    n_total++;
    if ({VPC_IMEM, access_is_inst_IMEM} !== {32'h100, 1'b1})
      $display("FAIL reset_vpc: got vpc=%h acc=%b want vpc=00000100 acc=1", VPC_IMEM, access_is_inst_IMEM);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({if_valid, if_pc, if_inst, if_fault} !== {1'b1, 32'h100 + 32'(4*i), mem_word(32'h100 + 32'(4*i)), 2'b00})
        $display("FAIL seq_pkt%0d: got v=%b pc=%h inst=%h f=%b want v=1 pc=%h inst=%h f=00",
                 i, if_valid, if_pc, if_inst, if_fault, 32'h100 + 32'(4*i), mem_word(32'h100 + 32'(4*i)));
      else n_pass++;
    end
    n_total++;
    if (VPC_IMEM !== 32'h10C)
      $display("FAIL seq_vpc: got %h want 0000010c", VPC_IMEM);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_branch(32'h200);
    stall_IMEM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if ({VPC_IMEM, if_valid} !== {32'h200, 1'b0})
        $display("FAIL stall_hold%0d: got vpc=%h v=%b want vpc=00000200 v=0", i, VPC_IMEM, if_valid);
      else n_pass++;
    end
    stall_IMEM = 1'b0;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_inst, VPC_IMEM} !== {1'b1, 32'h200, mem_word(32'h200), 32'h204})
      $display("FAIL stall_release: got v=%b pc=%h inst=%h vpc=%h want v=1 pc=00000200 inst=%h vpc=00000204",
               if_valid, if_pc, if_inst, VPC_IMEM, mem_word(32'h200));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_branch(32'h300);
    tick();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({if_valid, if_pc, VPC_IMEM} !== {1'b1, 32'h300, 32'h304})
        $display("FAIL bp_hold%0d: got v=%b pc=%h vpc=%h want v=1 pc=00000300 vpc=00000304",
                 i, if_valid, if_pc, VPC_IMEM);
      else n_pass++;
    end
    id_ready = 1'b1;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h304, mem_word(32'h304)})
      $display("FAIL bp_release: got v=%b pc=%h inst=%h want v=1 pc=00000304 inst=%h",
               if_valid, if_pc, if_inst, mem_word(32'h304));
    else n_pass++;
  endtask

  task automatic test_redirect_priority();
    trap_valid = 1'b1; trap_pc = 32'h80;
    br_valid   = 1'b1; br_pc   = 32'h400;
    tick();
    trap_valid = 1'b0; br_valid = 1'b0;
    n_total++;
    if ({if_valid, VPC_IMEM} !== {1'b0, 32'h80})
      $display("FAIL prio_squash: got v=%b vpc=%h want v=0 vpc=00000080", if_valid, VPC_IMEM);
    else n_pass++;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h80, mem_word(32'h80)})
      $display("FAIL prio_first: got v=%b pc=%h inst=%h want v=1 pc=00000080 inst=%h",
               if_valid, if_pc, if_inst, mem_word(32'h80));
    else n_pass++;
  endtask

  task automatic test_page_fault();
    do_branch(32'h1000);
    instr_fault_mmu_IMEM = 1'b1;
    faulting_va_IMEM     = 32'h1000;
    tick();
    instr_fault_mmu_IMEM = 1'b0;
    faulting_va_IMEM     = 32'h0;
    n_total++;
    if ({if_valid, if_pc, if_inst, if_fault, if_fault_va} !== {1'b1, 32'h1000, NOP, 2'b10, 32'h1000})
      $display("FAIL pf_packet: got v=%b pc=%h inst=%h f=%b va=%h want v=1 pc=00001000 inst=%h f=10 va=00001000",
               if_valid, if_pc, if_inst, if_fault, if_fault_va, NOP);
    else n_pass++;
    n_total++;
    if (access_is_inst_IMEM !== 1'b0)
      $display("FAIL pf_hold_state: got acc=%b want 0", access_is_inst_IMEM);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({if_valid, VPC_IMEM, access_is_inst_IMEM} !== {1'b0, 32'h1000, 1'b0})
        $display("FAIL pf_hold%0d: got v=%b vpc=%h acc=%b want v=0 vpc=00001000 acc=0",
                 i, if_valid, VPC_IMEM, access_is_inst_IMEM);
      else n_pass++;
    end
    do_branch(32'h2000);
    n_total++;
    if ({VPC_IMEM, access_is_inst_IMEM, if_valid} !== {32'h2000, 1'b1, 1'b0})
      $display("FAIL pf_redirect: got vpc=%h acc=%b v=%b want vpc=00002000 acc=1 v=0",
               VPC_IMEM, access_is_inst_IMEM, if_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_fault} !== {1'b1, 32'h2000, 2'b00})
      $display("FAIL pf_resume: got v=%b pc=%h f=%b want v=1 pc=00002000 f=00", if_valid, if_pc, if_fault);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    do_branch(32'h502);
    tick();
    n_total++;
    if ({if_valid, if_pc, if_inst, if_fault, if_fault_va} !== {1'b1, 32'h502, NOP, 2'b01, 32'h502})
      $display("FAIL mis_packet: got v=%b pc=%h inst=%h f=%b va=%h want v=1 pc=00000502 inst=%h f=01 va=00000502",
               if_valid, if_pc, if_inst, if_fault, if_fault_va, NOP);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({if_valid, VPC_IMEM, access_is_inst_IMEM} !== {1'b0, 32'h502, 1'b0})
        $display("FAIL mis_hold%0d: got v=%b vpc=%h acc=%b want v=0 vpc=00000502 acc=0",
                 i, if_valid, VPC_IMEM, access_is_inst_IMEM);
      else n_pass++;
    end
    trap_valid = 1'b1; trap_pc = 32'h600;
    tick();
    trap_valid = 1'b0;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_fault, VPC_IMEM} !== {1'b1, 32'h600, 2'b00, 32'h604})
      $display("FAIL mis_resume: got v=%b pc=%h f=%b vpc=%h want v=1 pc=00000600 f=00 vpc=00000604",
               if_valid, if_pc, if_fault, VPC_IMEM);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_branch(32'hFFFF_FFFC);
    tick();
    n_total++;
    if ({if_valid, if_pc, VPC_IMEM} !== {1'b1, 32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap: got v=%b pc=%h vpc=%h want v=1 pc=fffffffc vpc=00000000",
               if_valid, if_pc, VPC_IMEM);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    tick();
    rst = 1'b1;
    #1;
    n_total++;
    if ({if_valid, if_pc, if_inst, VPC_IMEM, access_is_inst_IMEM} !== {1'b0, 32'd0, NOP, 32'h100, 1'b1})
      $display("FAIL async_rst: got v=%b pc=%h inst=%h vpc=%h acc=%b want v=0 pc=0 inst=%h vpc=00000100 acc=1",
               if_valid, if_pc, if_inst, VPC_IMEM, access_is_inst_IMEM, NOP);
    else n_pass++;
`ifdef FETCH_STATS_EN
    n_total++;
    if ({perf_fetched, perf_stall_mmu, perf_redirect} !== 96'd0)
      $display("FAIL perf_rst: got %h %h %h want 0 0 0", perf_fetched, perf_stall_mmu, perf_redirect);
    else n_pass++;
`endif
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h100, mem_word(32'h100)})
      $display("FAIL async_first: got v=%b pc=%h inst=%h want v=1 pc=00000100 inst=%h",
               if_valid, if_pc, if_inst, mem_word(32'h100));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_backpressure();
    test_redirect_priority();
    test_page_fault();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
